// File: rtl/argmax_stream.sv
// argmax_stream
//   Streaming argmax over one packed vector of NUM_INPUT scores, scanned
//   LANES elements per cycle. Reports the index and value of the maximum
//   and the margin (max minus runner-up) as a confidence measure.
//
// Ports
//   clk       clock, all state changes on the rising edge
//   rst       asynchronous, active-low reset
//   i_data    packed scores, element n at [n*INPUT_WIDTH +: INPUT_WIDTH]
//   i_valid   i_data valid
//   i_ready   vector can be accepted this cycle
//   o_index   index of the maximum (lowest index on ties)
//   o_value   maximum score
//   o_margin  max minus runner-up, modulo 2^INPUT_WIDTH
//   o_valid   result valid, held until o_ready
//   o_ready   consumer accepts the result
module argmax_stream #(
  parameter int NUM_INPUT   = 10,
  parameter int INPUT_WIDTH = 16,
  parameter int LANES       = 1,
  parameter int SIGNED_CMP  = 0,
  parameter int INDEX_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUT*INPUT_WIDTH-1:0] i_data,
  input  logic                             i_valid,
  output logic                             i_ready,
  output logic [INDEX_WIDTH-1:0]           o_index,
  output logic [INPUT_WIDTH-1:0]           o_value,
  output logic [INPUT_WIDTH-1:0]           o_margin,
  output logic                             o_valid,
  input  logic                             o_ready
);

  localparam int W     = INPUT_WIDTH;
  localparam int DW    = NUM_INPUT * INPUT_WIDTH;
  // Wide enough to hold the pointer after its final increment.
  localparam int PTR_W = $clog2(NUM_INPUT + LANES + 1);
  // Smallest representable score: runner-up seed before any element is seen.
  localparam logic [W-1:0] MIN_VAL = (SIGNED_CMP != 0) ? (W'(1) << (W - 1)) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t                 state_q;
  // Holds the not-yet-scanned elements; shifted down by LANES elements per
  // scan cycle so that lane l always reads slot l.
  logic [DW-1:0]          buf_q;
  logic [W-1:0]           max_q;
  logic [W-1:0]           sec_q;
  logic [PTR_W-1:0]       idx_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [INDEX_WIDTH-1:0] o_index_q;
  logic [W-1:0]           o_value_q;
  logic [W-1:0]           o_margin_q;
  logic                   o_valid_q;

  logic [W-1:0]           max_d;
  logic [W-1:0]           sec_d;
  logic [PTR_W-1:0]       idx_d;
  logic                   accept;
  logic                   scan_last;

  logic [W-1:0]           lane_val [LANES];
  logic [PTR_W-1:0]       lane_pos [LANES];
  logic [LANES-1:0]       lane_live;

  function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b);
    if (SIGNED_CMP != 0) begin
      return $signed(a) > $signed(b);
    end else begin
      return a > b;
    end
  endfunction

  // Per-lane candidate, its element index, and whether it lies inside the
  // vector (the final scan cycle may be only partly populated).
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_val[gi]  = buf_q[gi*W +: W];
      assign lane_pos[gi]  = ptr_q + PTR_W'(gi);
      assign lane_live[gi] = lane_pos[gi] < PTR_W'(NUM_INPUT);
    end
  endgenerate

  // Combinational compare chain in ascending index order. Strict
  // greater-than keeps the lowest index on ties; an equal value still
  // raises the runner-up so a tie yields margin 0.
  always_comb begin
    max_d = max_q;
    sec_d = sec_q;
    idx_d = idx_q;
    for (int l = 0; l < LANES; l++) begin
      if (lane_live[l]) begin
        if (gt(lane_val[l], max_d)) begin
          sec_d = max_d;
          max_d = lane_val[l];
          idx_d = lane_pos[l];
        end else if (gt(lane_val[l], sec_d)) begin
          sec_d = lane_val[l];
        end
      end
    end
  end

  assign scan_last = (ptr_q + PTR_W'(LANES)) >= PTR_W'(NUM_INPUT);

  // DONE with o_ready high doubles as an accept slot for back-to-back vectors.
  assign i_ready = rst & ((state_q == IDLE) | ((state_q == DONE) & o_ready));
  assign accept  = i_valid & i_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      max_q      <= '0;
      sec_q      <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
      o_index_q  <= '0;
      o_value_q  <= '0;
      o_margin_q <= '0;
      o_valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            // Element 0 seeds the maximum; the rest wait in the buffer.
            buf_q <= i_data >> W;
            max_q <= i_data[W-1:0];
            sec_q <= MIN_VAL;
            idx_q <= '0;
            ptr_q <= PTR_W'(1);
            if (NUM_INPUT == 1) begin
              state_q    <= DONE;
              o_index_q  <= '0;
              o_value_q  <= i_data[W-1:0];
              o_margin_q <= i_data[W-1:0] - MIN_VAL;
              o_valid_q  <= 1'b1;
            end else begin
              state_q   <= SCAN;
              o_valid_q <= 1'b0;
            end
          end else if ((state_q == DONE) && o_ready) begin
            state_q   <= IDLE;
            o_valid_q <= 1'b0;
          end
        end
        SCAN: begin
          max_q <= max_d;
          sec_q <= sec_d;
          idx_q <= idx_d;
          ptr_q <= ptr_q + PTR_W'(LANES);
          buf_q <= buf_q >> (LANES * W);
          if (scan_last) begin
            state_q    <= DONE;
            o_index_q  <= INDEX_WIDTH'(idx_d);
            o_value_q  <= max_d;
            o_margin_q <= max_d - sec_d;
            o_valid_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_index  = o_index_q;
  assign o_value  = o_value_q;
  assign o_margin = o_margin_q;
  assign o_valid  = o_valid_q;

endmodule

// File: tb/tb_argmax_stream.sv
// tb_argmax_stream
//   Drives three argmax_stream builds in lockstep from shared inputs:
//     u0 default (unsigned, 1 lane), u1 signed compare, u2 4 lanes.
//   Expected results come from a reference argmax over the whole vector.
module tb_argmax_stream;

  localparam int N = 10;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] i_data;
  logic           i_valid;
  logic           o_ready;

  logic [2:0]        rdy;
  logic [2:0]        vld;
  logic [2:0][W-1:0] idx_w;
  logic [2:0][W-1:0] val_w;
  logic [2:0][W-1:0] mar_w;

  int n_checks = 0;
  int n_errors = 0;

  int lat_exp [3] = '{9, 9, 3};
  bit sgn     [3] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  argmax_stream u0 (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_ready(rdy[0]),
    .o_index(idx_w[0]), .o_value(val_w[0]), .o_margin(mar_w[0]),
    .o_valid(vld[0]), .o_ready(o_ready)
  );

  argmax_stream #(.SIGNED_CMP(1)) u1 (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_ready(rdy[1]),
    .o_index(idx_w[1]), .o_value(val_w[1]), .o_margin(mar_w[1]),
    .o_valid(vld[1]), .o_ready(o_ready)
  );

  argmax_stream #(.LANES(4)) u2 (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_ready(rdy[2]),
    .o_index(idx_w[2]), .o_value(val_w[2]), .o_margin(mar_w[2]),
    .o_valid(vld[2]), .o_ready(o_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit greater(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    return s ? ($signed(a) > $signed(b)) : (a > b);
  endfunction

  // Reference: max over all elements (first occurrence wins), runner-up is
  // the largest of all remaining elements, or the minimum value if none.
  task automatic model(input logic [N*W-1:0] d, input bit s,
                       output logic [W-1:0] e_idx, output logic [W-1:0] e_val,
                       output logic [W-1:0] e_mar);
    int best;
    logic [W-1:0] sec;
    bit have;
    best = 0;
    for (int n = 1; n < N; n++)
      if (greater(d[n*W +: W], d[best*W +: W], s)) best = n;
    have = 1'b0;
    sec  = s ? 16'h8000 : 16'h0000;
    for (int n = 0; n < N; n++) begin
      if (n != best && (!have || greater(d[n*W +: W], sec, s))) begin
        sec  = d[n*W +: W];
        have = 1'b1;
      end
    end
    e_idx = W'(best);
    e_val = d[best*W +: W];
    e_mar = e_val - sec;
  endtask

  function automatic logic [N*W-1:0] pack(input logic [W-1:0] v [N]);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = v[i];
    return r;
  endfunction

  // Present a vector for exactly one edge; all builds must take it.
  task automatic accept_vec(input logic [N*W-1:0] d, input logic ordy);
    @(negedge clk);
    i_data  = d;
    i_valid = 1'b1;
    o_ready = ordy;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("accept_ready[%0d]", k), 32'(rdy[k]), 32'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    o_ready = 1'b0;
    // Garbage on the bus while scanning must not disturb the result.
    i_data  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    for (int k = 0; k < 3; k++) chk($sformatf("post_accept_valid[%0d]", k), 32'(vld[k]), 32'd0);
    chk("scan_ready[0]", 32'(rdy[0]), 32'd0);
  endtask

  // Measure latency from the accept edge and check each result.
  task automatic wait_check(input logic [N*W-1:0] d);
    int lat [3];
    logic [W-1:0] ei, ev, em;
    lat = '{-1, -1, -1};
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++)
        if (lat[k] < 0 && vld[k]) lat[k] = c;
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
    end
    for (int k = 0; k < 3; k++) begin
      model(d, sgn[k], ei, ev, em);
      chk($sformatf("latency[%0d]", k), 32'(lat[k]), 32'(lat_exp[k]));
      chk($sformatf("valid[%0d]", k), 32'(vld[k]), 32'd1);
      chk($sformatf("index[%0d]", k), 32'(idx_w[k]), 32'(ei));
      chk($sformatf("value[%0d]", k), 32'(val_w[k]), 32'(ev));
      chk($sformatf("margin[%0d]", k), 32'(mar_w[k]), 32'(em));
    end
    $display("vector %h -> u0 idx=%0d val=%h mar=%h | u1 idx=%0d val=%h mar=%h | u2 idx=%0d val=%h mar=%h",
             d, idx_w[0], val_w[0], mar_w[0], idx_w[1], val_w[1], mar_w[1],
             idx_w[2], val_w[2], mar_w[2]);
  endtask

  // One-cycle o_ready pulse; results must stay after the handshake.
  task automatic release_out(input logic [N*W-1:0] d);
    logic [W-1:0] ei, ev, em;
    @(negedge clk);
    o_ready = 1'b1;
    @(posedge clk);
    #1;
    o_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      model(d, sgn[k], ei, ev, em);
      chk($sformatf("released_valid[%0d]", k), 32'(vld[k]), 32'd0);
      chk($sformatf("idle_ready[%0d]", k), 32'(rdy[k]), 32'd1);
      chk($sformatf("held_value[%0d]", k), 32'(val_w[k]), 32'(ev));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]   v [N];
    logic [N*W-1:0] d;
    logic [W-1:0]   ei, ev, em;

    rst     = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b0;
    i_data  = '0;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_valid[%0d]", k), 32'(vld[k]), 32'd0);
      chk($sformatf("rst_index[%0d]", k), 32'(idx_w[k]), 32'd0);
      chk($sformatf("rst_value[%0d]", k), 32'(val_w[k]), 32'd0);
      chk($sformatf("rst_margin[%0d]", k), 32'(mar_w[k]), 32'd0);
      chk($sformatf("rst_ready[%0d]", k), 32'(rdy[k]), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("ready_after_rst[%0d]", k), 32'(rdy[k]), 32'd1);

    // Documented example: tie on 9 at indices 3 and 5.
    v = '{16'd3, 16'd7, 16'd2, 16'd9, 16'd1, 16'd9, 16'd0, 16'd4, 16'd5, 16'd8};
    d = pack(v);
    accept_vec(d, 1'b0);
    wait_check(d);
    chk("example_index", 32'(idx_w[0]), 32'd3);
    chk("example_margin", 32'(mar_w[0]), 32'd0);
    release_out(d);

    // Sign handling.
    v = '{16'hFFFF, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    d = pack(v);
    accept_vec(d, 1'b0);
    wait_check(d);
    chk("unsigned_margin", 32'(mar_w[0]), 32'hFFFE);
    chk("signed_index", 32'(idx_w[1]), 32'd1);
    chk("signed_margin", 32'(mar_w[1]), 32'd1);
    release_out(d);

    // Maximum in the last, partly populated lane group.
    for (int i = 0; i < N; i++) v[i] = 16'h0010;
    v[9] = 16'h1234;
    d = pack(v);
    accept_vec(d, 1'b0);
    wait_check(d);
    chk("lanes_index", 32'(idx_w[2]), 32'd9);
    chk("lanes_margin", 32'(mar_w[2]), 32'h1224);

    release_out(d);

    // Backpressure, then back-to-back accept from DONE.
    for (int i = 0; i < N; i++) v[i] = 16'($urandom);
    d = pack(v);
    accept_vec(d, 1'b0);
    wait_check(d);
    model(d, 1'b0, ei, ev, em);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(vld[0]), 32'd1);
      chk("hold_ready", 32'(rdy[0]), 32'd0);
      chk("hold_index", 32'(idx_w[0]), 32'(ei));
      chk("hold_value", 32'(val_w[0]), 32'(ev));
      chk("hold_margin", 32'(mar_w[0]), 32'(em));
    end
    for (int i = 0; i < N; i++) v[i] = 16'($urandom);
    d = pack(v);
    accept_vec(d, 1'b1);
    wait_check(d);
    release_out(d);

    // Random vectors: small values (ties), full range, values around wrap.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++) begin
        case (r % 3)
          0:       v[i] = 16'($urandom_range(0, 3));
          1:       v[i] = 16'($urandom);
          default: v[i] = 16'hFFFE + 16'($urandom_range(0, 3));
        endcase
      end
      d = pack(v);
      accept_vec(d, 1'b0);
      wait_check(d);
      release_out(d);
    end

    // Reset four cycles after accept: u0/u1 mid-scan, u2 already done.
    for (int i = 0; i < N; i++) v[i] = 16'($urandom_range(1, 16'hFFFF));
    d = pack(v);
    accept_vec(d, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_done_valid[2]", 32'(vld[2]), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("abort_valid[%0d]", k), 32'(vld[k]), 32'd0);
      chk($sformatf("abort_index[%0d]", k), 32'(idx_w[k]), 32'd0);
      chk($sformatf("abort_value[%0d]", k), 32'(val_w[k]), 32'd0);
      chk($sformatf("abort_margin[%0d]", k), 32'(mar_w[k]), 32'd0);
      chk($sformatf("abort_ready[%0d]", k), 32'(rdy[k]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("ready_after_abort[%0d]", k), 32'(rdy[k]), 32'd1);

    for (int i = 0; i < N; i++) v[i] = 16'd5;
    d = pack(v);
    accept_vec(d, 1'b0);
    wait_check(d);
    chk("equal_index", 32'(idx_w[0]), 32'd0);
    chk("equal_value", 32'(val_w[0]), 32'd5);
    chk("equal_margin", 32'(mar_w[0]), 32'd0);
    release_out(d);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
